// File: rtl/fivesons_pkg.sv
// Shared FiveSons definitions: board geometry, cell/status encodings, display colours.
package fivesons_pkg;

    localparam int BOARD_SIDE = 16;
    localparam int CELL_BITS  = 2;
    localparam int BOARD_BITS = BOARD_SIDE * BOARD_SIDE * CELL_BITS;

    localparam logic [1:0] CELL_EMPTY = 2'b11;
    localparam logic [1:0] CELL_A     = 2'b01;
    localparam logic [1:0] CELL_B     = 2'b10;
    localparam logic [1:0] CELL_RSVD  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_A_WON   = 2'b01,
        ST_PLAYING = 2'b10,
        ST_B_WON   = 2'b11
    } game_status_e;

    localparam logic [2:0] COL_CURSOR     = 3'b100;
    localparam logic [2:0] COL_STONE_A    = 3'b111;
    localparam logic [2:0] COL_STONE_B    = 3'b000;
    localparam logic [2:0] COL_RSVD       = 3'b101;
    localparam logic [2:0] COL_EMPTY_PLAY = 3'b110;
    localparam logic [2:0] COL_EMPTY_AWON = 3'b010;
    localparam logic [2:0] COL_EMPTY_BWON = 3'b011;
    localparam logic [2:0] COL_EMPTY_IDLE = 3'b001;

    // Bit offset of cell (cx,cy) inside the board word: cx*2 + cy*32.
    function automatic logic [8:0] cell_offset(input logic [3:0] cx, input logic [3:0] cy);
        return {cy, cx, 1'b0};
    endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Pixel-plot link between the board renderer and the VGA adapter frame buffer.
interface board_renderer_if;
    logic       plot;
    logic       plot_ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       frame_done;

    modport master (output plot, x, y, colour, frame_done, input plot_ready);
    modport slave  (input plot, x, y, colour, frame_done, output plot_ready);
endinterface

// File: rtl/cell_colour_lut.sv
// Maps a cell code, game status and cursor-border flag to a 3-bit RGB colour.
module cell_colour_lut
    import fivesons_pkg::*;
(
    input  logic [1:0] cell_i,
    input  logic [1:0] status_i,
    input  logic       cursor_border_i,
    output logic [2:0] colour_o
);

    always_comb begin
        colour_o = COL_RSVD;
        if (cursor_border_i) begin
            colour_o = COL_CURSOR;
        end else begin
            case (cell_i)
                CELL_EMPTY: begin
                    case (status_i)
                        ST_PLAYING: colour_o = COL_EMPTY_PLAY;
                        ST_A_WON:   colour_o = COL_EMPTY_AWON;
                        ST_B_WON:   colour_o = COL_EMPTY_BWON;
                        default:    colour_o = COL_EMPTY_IDLE;
                    endcase
                end
                CELL_A:  colour_o = COL_STONE_A;
                CELL_B:  colour_o = COL_STONE_B;
                default: colour_o = COL_RSVD;
            endcase
        end
    end

endmodule

// File: rtl/board_renderer.sv
// Serialises a snapshot of the gomoku board into pixel-plot requests, one frame per snapshot.
module board_renderer
    import fivesons_pkg::*;
#(
    parameter int CELL_PX  = 7,
    parameter int ORIGIN_X = 24,
    parameter int ORIGIN_Y = 4
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic                  enable,
    input  logic [BOARD_BITS-1:0] board,
    input  logic [1:0]            gaming_status,
    input  logic [3:0]            pointer_loc_x,
    input  logic [3:0]            pointer_loc_y,
    board_renderer_if.master      vga
);

    localparam int PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam logic [PW-1:0] PX_MAX = PW'(CELL_PX - 1);

    typedef enum logic [1:0] {IDLE, SNAP, DRAW, DONE} state_e;

    state_e                state_q, state_d;
    logic [BOARD_BITS-1:0] board_q, board_d;
    logic [1:0]            status_q, status_d;
    logic [3:0]            ptr_x_q, ptr_x_d, ptr_y_q, ptr_y_d;
    logic [PW-1:0]         px_q, px_d, py_q, py_d;
    logic [3:0]            cx_q, cx_d, cy_q, cy_d;
    logic                  plot_q, plot_d, frame_done_q, frame_done_d;
    logic [7:0]            x_q, x_d;
    logic [6:0]            y_q, y_d;
    logic [2:0]            colour_q, colour_d;
    logic                  load_pix, cursor_border;
    logic [2:0]            lut_colour;

    // Colour of the pixel about to be presented; board_d is the live input during
    // SNAP and the snapshot otherwise, so the first pixel needs no extra cycle.
    assign cursor_border = (cx_d == ptr_x_d) && (cy_d == ptr_y_d) &&
                           ((px_d == '0) || (px_d == PX_MAX) || (py_d == '0) || (py_d == PX_MAX));

    cell_colour_lut u_lut (
        .cell_i          (board_d[cell_offset(cx_d, cy_d) +: CELL_BITS]),
        .status_i        (status_d),
        .cursor_border_i (cursor_border),
        .colour_o        (lut_colour)
    );

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        status_d = status_q;
        ptr_x_d  = ptr_x_q;
        ptr_y_d  = ptr_y_q;
        px_d     = px_q;
        py_d     = py_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        load_pix = 1'b0;
        case (state_q)
            IDLE: if (enable) state_d = SNAP;
            SNAP: begin
                board_d  = board;
                status_d = gaming_status;
                ptr_x_d  = pointer_loc_x;
                ptr_y_d  = pointer_loc_y;
                px_d     = '0;
                py_d     = '0;
                cx_d     = '0;
                cy_d     = '0;
                load_pix = 1'b1;
                state_d  = DRAW;
            end
            DRAW: begin
                if (plot_q && vga.plot_ready) begin
                    if (px_q == PX_MAX && py_q == PX_MAX && cx_q == 4'hF && cy_q == 4'hF) begin
                        state_d = DONE;
                    end else begin
                        load_pix = 1'b1;
                        if (px_q != PX_MAX) begin
                            px_d = px_q + 1'b1;
                        end else begin
                            px_d = '0;
                            if (py_q != PX_MAX) begin
                                py_d = py_q + 1'b1;
                            end else begin
                                py_d = '0;
                                cx_d = cx_q + 4'd1;
                                if (cx_q == 4'hF) cy_d = cy_q + 4'd1;
                            end
                        end
                    end
                end
            end
            DONE: state_d = enable ? SNAP : IDLE;
            default: state_d = IDLE;
        endcase

        plot_d       = (state_d == DRAW);
        frame_done_d = (state_d == DONE);
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        if (load_pix) begin
            x_d      = 8'(9'(ORIGIN_X) + 9'(cx_d) * 9'(CELL_PX) + 9'(px_d));
            y_d      = 7'(9'(ORIGIN_Y) + 9'(cy_d) * 9'(CELL_PX) + 9'(py_d));
            colour_d = lut_colour;
        end
    end

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            board_q      <= '0;
            status_q     <= '0;
            ptr_x_q      <= '0;
            ptr_y_q      <= '0;
            px_q         <= '0;
            py_q         <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            plot_q       <= 1'b0;
            frame_done_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            status_q     <= status_d;
            ptr_x_q      <= ptr_x_d;
            ptr_y_q      <= ptr_y_d;
            px_q         <= px_d;
            py_q         <= py_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            plot_q       <= plot_d;
            frame_done_q <= frame_done_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
        end
    end

    assign vga.plot       = plot_q;
    assign vga.frame_done = frame_done_q;
    assign vga.x          = x_q;
    assign vga.y          = y_q;
    assign vga.colour     = colour_q;

endmodule
